store_capture_fifo: RTL
=======================

// Module: store_capture_fifo
// PURPOSE
//  Sits directly downstream of the processor top's data-memory write port.
//  Snoops every store (MemWrite/DataAdr/WriteData) whose address falls in the
//  result window and buffers the (address, data) pair in a FIFO.
//  Drains the pairs over a valid/ready handshake to the display/UART output stage.
//  Keeps the encrypted/decrypted characters in program order, with overflow accounting.
// PARAMETERS
//  DW       8   data width, matches WriteData
//  AW       8   address width, matches DataAdr
//  DEPTH    16  FIFO entries; power of two, >= 2
//  ADDR_LO  1   lowest captured address, inclusive
//  ADDR_HI  21  highest captured address, inclusive
// PORTS
//  clk        in   1              rising-edge clock shared with top
//  reset      in   1              synchronous, active-high
//  MemWrite   in   1              store strobe from processor
//  DataAdr    in   AW             store address
//  WriteData  in   DW             store data
//  out_valid  out  1              head entry available
//  out_ready  in   1              consumer accepts head this cycle
//  out_addr   out  AW             address of head entry
//  out_data   out  DW             data of head entry
//  count      out  $clog2(DEPTH)+1  current occupancy
//  full       out  1              count == DEPTH
//  overflow   out  1              sticky: a store was dropped since reset
//  drop_cnt   out  8              dropped stores, saturates at 255
// BEHAVIOUR
//  - Reset (sync, active-high): wr/rd pointers=0, count=0, out_valid=0, full=0,
//    overflow=0, drop_cnt=0. Storage array is not cleared. out_addr/out_data
//    are don't-care while out_valid=0. Reset mid-drain discards all entries.
//  - hit = MemWrite && ADDR_LO <= DataAdr <= ADDR_HI (unsigned compare).
//    Stores outside the window are ignored and not counted as drops.
//  - push = hit && (!full || pop). pop = out_valid && out_ready.
//  - Push at edge N: {DataAdr, WriteData} is written at wr_ptr, and wr_ptr
//    increments. If the FIFO was empty, out_valid=1 and the entry is on
//    out_addr/out_data after edge N (1-cycle latency). There is no
//    same-cycle bypass.
//  - Show-ahead: out_addr/out_data always reflect the head entry. Both are
//    stable while out_valid && !out_ready.
//  - Pop at edge N: rd_ptr increments, and the next entry (if any) is
//    presented after edge N.
//  - Pointers wrap modulo DEPTH. count = pushes - pops, and never exceeds DEPTH.
//  - Simultaneous push+pop: count is unchanged. This is allowed when full,
//    because the pop frees the slot. Push+pop when count==1 keeps out_valid=1
//    and presents the new entry.
//  - hit && full && !pop: the store is dropped. overflow<=1 (sticky until reset),
//    and drop_cnt increments, holding at 255.
//  - out_ready while !out_valid has no effect. Valid is never withdrawn
//    without a pop or reset.
//  - One store per cycle max (single-cycle core). No internal state machine
//    beyond the pointers and counters; all outputs are registered or decoded
//    from registers.
// TESTING
//  1. Reset, then stores 67,65,83,65 to addr 1..4 on consecutive cycles,
//     out_ready=1 -> out emits (1,67),(2,65),(3,83),(4,65) in order, each one
//     cycle after its store; overflow=0.
//  2. out_ready=0, stores to addr 5..8 with data 77,69,83,65 -> count=4 and
//     head stays (5,77) stable; then raise out_ready -> drains in order, count
//     returns to 0, out_valid=0.
//  3. Stores to addr 0, 22 and 200, plus MemWrite=0 cycles with addr 9 ->
//     count stays 0 and drop_cnt=0.
//  4. out_ready=0, 18 in-window stores -> full=1 after 16, overflow=1,
//     drop_cnt=2; drain -> the first 16 data values appear, the last 2 do not.
//  5. FIFO full, same cycle: in-window store plus out_ready=1 -> store
//     accepted, count stays 16, drop_cnt unchanged.
//  6. With 3 entries queued, assert reset for 1 cycle mid-drain -> next cycle
//     out_valid=0, count=0, overflow=0; a following store to addr 9 (76)
//     appears as the head.

Source files
------------

// File: rtl/store_capture_fifo.sv
// Snoops processor stores that land in the result window and queues the
// (address, data) pairs for a valid/ready consumer, counting any it had to drop.
module store_capture_fifo #(
    parameter int unsigned DW      = 8,
    parameter int unsigned AW      = 8,
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned ADDR_LO = 1,
    parameter int unsigned ADDR_HI = 21
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       MemWrite,
    input  logic [AW-1:0]              DataAdr,
    input  logic [DW-1:0]              WriteData,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [AW-1:0]              out_addr,
    output logic [DW-1:0]              out_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       overflow,
    output logic [7:0]                 drop_cnt
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [AW-1:0] LO = AW'(ADDR_LO);
    localparam logic [AW-1:0] HI = AW'(ADDR_HI);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [AW+DW-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_overflow;
    logic [7:0]       r_drop_cnt;

    logic w_hit;
    logic w_full;
    logic w_valid;
    logic w_pop;
    logic w_push;
    logic w_drop;

    assign w_hit   = MemWrite && (DataAdr >= LO) && (DataAdr <= HI);
    assign w_full  = (r_count == FULL_COUNT);
    assign w_valid = (r_count != '0);
    assign w_pop   = w_valid && out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_push  = w_hit && (!w_full || w_pop);
    assign w_drop  = w_hit && !w_push;

    // Storage is deliberately left out of reset so it maps onto LUT RAM.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {DataAdr, WriteData};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_cnt != 8'hFF) begin
                    r_drop_cnt <= r_drop_cnt + 8'd1;
                end
            end
        end
    end

    // Show-ahead: the head slot is always on the output bus.
    assign {out_addr, out_data} = r_mem[r_rd_ptr];
    assign out_valid = w_valid;
    assign count     = r_count;
    assign full      = w_full;
    assign overflow  = r_overflow;
    assign drop_cnt  = r_drop_cnt;

endmodule
